// File: rtl/reg_file_param.sv
// reg_file_param: parametrised CPU register file for the neuron-core pipeline.
// NUM_RD combinational read ports, one synchronous write port, optional hardwired-zero reg 0,
// interrupt context capture (PC into REG[DEPTH-2], random seed into REG[DEPTH-1]) and a
// sequenced soft clear that zeroes one register per cycle.
// Optional feature macro: REG_FILE_BYPASS_EN (same-cycle write/capture forwarding to read ports).
module reg_file_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [DATA_W-1:0]          IN,
    input  logic [ADDR_W-1:0]          INADDRESS,
    input  logic                       WRITE_EN,
    input  logic [NUM_RD*ADDR_W-1:0]   OUTADDRESS,
    output logic [NUM_RD*DATA_W-1:0]   OUT,
    input  logic                       IRQ_SAVE,
    input  logic [DATA_W-1:0]          PC_IN,
    input  logic [DATA_W-1:0]          RAND_IN,
    input  logic                       CLEAR_REQ,
    output logic                       BUSY,
    output logic                       CLEAR_DONE
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_PC   = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] ADDR_RAND = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   hold_pc_q, hold_pc_d;
    logic [DATA_W-1:0]   hold_rand_q, hold_rand_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];

    // Control FSM next state: clear sequencing and interrupt-pending bookkeeping.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        hold_pc_d   = hold_pc_q;
        hold_rand_d = hold_rand_q;
        case (state_q)
            ST_IDLE: begin
                if (CLEAR_REQ) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
                // Interrupts during a clear are parked; the latest pulse wins.
                if (IRQ_SAVE) begin
                    pend_d      = 1'b1;
                    hold_pc_d   = PC_IN;
                    hold_rand_d = RAND_IN;
                end else begin
                    pend_d      = pend_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Register array next state: writes, interrupt capture and clear zeroing.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (WRITE_EN) begin
                    regs_d[INADDRESS] = IN;
                end else begin
                    regs_d[INADDRESS] = regs_q[INADDRESS];
                end
                // Capture is applied after the write so it overrides a write to the same slots.
                if (IRQ_SAVE) begin
                    regs_d[ADDR_PC]   = PC_IN;
                    regs_d[ADDR_RAND] = RAND_IN;
                end else begin
                    regs_d[ADDR_PC]   = regs_d[ADDR_PC];
                end
            end
            ST_CLEAR: begin
                regs_d[idx_q] = '0;
            end
            ST_DONE: begin
                // A fresh pulse on the DONE cycle is newer than anything parked.
                if (IRQ_SAVE) begin
                    regs_d[ADDR_PC]   = PC_IN;
                    regs_d[ADDR_RAND] = RAND_IN;
                end else if (pend_q) begin
                    regs_d[ADDR_PC]   = hold_pc_q;
                    regs_d[ADDR_RAND] = hold_rand_q;
                end else begin
                    regs_d[ADDR_PC]   = regs_q[ADDR_PC];
                end
            end
            default: begin
                regs_d[0] = regs_q[0];
            end
        endcase
        if (ZERO_R0 != 0) begin
            regs_d[0] = '0;
        end else begin
            regs_d[0] = regs_d[0];
        end
    end

    // State, counters and holding registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            hold_pc_q   <= '0;
            hold_rand_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            hold_pc_q   <= hold_pc_d;
            hold_rand_q <= hold_rand_d;
        end
    end

    // Register storage with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Status flags decode straight from the state register, so they are glitch-free.
    assign BUSY       = (state_q == ST_CLEAR);
    assign CLEAR_DONE = (state_q == ST_DONE);

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;

        assign ra_s = OUTADDRESS[k*ADDR_W +: ADDR_W];

        // Read port mux: stored value, optional same-cycle forwarding, zero for reg 0.
        always_comb begin
            rd_s = regs_q[ra_s];
`ifdef REG_FILE_BYPASS_EN
            if (state_q == ST_IDLE) begin
                if (IRQ_SAVE && (ra_s == ADDR_PC)) begin
                    rd_s = PC_IN;
                end else if (IRQ_SAVE && (ra_s == ADDR_RAND)) begin
                    rd_s = RAND_IN;
                end else if (WRITE_EN && (ra_s == INADDRESS)) begin
                    rd_s = IN;
                end else begin
                    rd_s = regs_q[ra_s];
                end
            end else begin
                rd_s = regs_q[ra_s];
            end
`endif
            if ((ZERO_R0 != 0) && (ra_s == '0)) begin
                rd_s = '0;
            end else begin
                rd_s = rd_s;
            end
        end

        assign OUT[k*DATA_W +: DATA_W] = rd_s;
    end

endmodule
